// File: rtl/y86_regfile_wb.sv
// y86_regfile_wb: write-back stage and architectural register file for the
// pipelined Y86-64 core. Two combinational read ports with same-cycle
// write-through bypass, a sticky halt state and a retired-instruction counter.
//
// state      | meaning
// -----------+------------------------------------------------------------
// ST_RUN     | normal operation, AOK instructions commit and retire
// ST_HALTED  | a non-AOK status reached W; writes and counting frozen
//              until reset
module y86_regfile_wb #(
  parameter int DATA_W = 64,
  parameter int NREG   = 15,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wb_valid,
  input  logic [3:0]        wb_stat,
  input  logic [3:0]        dstE,
  input  logic [DATA_W-1:0] valE,
  input  logic [3:0]        dstM,
  input  logic [DATA_W-1:0] valM,
  input  logic [3:0]        srcA,
  input  logic [3:0]        srcB,
  output logic [DATA_W-1:0] valA,
  output logic [DATA_W-1:0] valB,
  output logic              halted,
  output logic [3:0]        halt_code,
  output logic [CNT_W-1:0]  retired
);

  localparam logic [3:0] STAT_AOK = 4'd1;

  typedef enum logic {
    ST_RUN    = 1'b0,
    ST_HALTED = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic [3:0]        halt_code_q, halt_code_d;
  logic [CNT_W-1:0]  retired_q;
  logic [DATA_W-1:0] regs [NREG];

  logic commit;
  logic fault;
  logic weE;
  logic weM;

  // Ids at or above NREG (including 4'hF) address nothing.
  function automatic logic id_ok(input logic [3:0] id);
    return int'(id) < NREG;
  endfunction

  assign halted    = (state_q == ST_HALTED);
  assign halt_code = halt_code_q;
  assign retired   = retired_q;

  assign commit = wb_valid & (wb_stat == STAT_AOK) & ~halted & ~reset;
  assign fault  = wb_valid & (wb_stat != STAT_AOK) & ~halted & ~reset;
  assign weE    = commit & id_ok(dstE);
  assign weM    = commit & id_ok(dstM);

  // Halt state register and the status code that caused the halt.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_RUN;
      halt_code_q <= 4'd0;
    end else begin
      state_q     <= state_d;
      halt_code_q <= halt_code_d;
    end
  end

  // Next-state: the first faulting instruction stops the machine; only reset leaves HALTED.
  always_comb begin
    state_d     = state_q;
    halt_code_d = halt_code_q;
    case (state_q)
      ST_RUN: begin
        if (fault) begin
          state_d     = ST_HALTED;
          halt_code_d = wb_stat;
        end
      end
      ST_HALTED: begin
        state_d = ST_HALTED;
      end
      default: begin
        state_d = ST_RUN;
      end
    endcase
  end

  // Retired-instruction counter, wraps naturally at 2^CNT_W.
  always_ff @(posedge clk) begin
    if (reset) begin
      retired_q <= '0;
    end else if (commit) begin
      retired_q <= retired_q + CNT_W'(1);
    end
  end

  // Register array; the M port is tested first so valM wins a dstE==dstM collision.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NREG; i++) begin
      if (reset) begin
        regs[i] <= '0;
      end else if (weM && (dstM == 4'(i))) begin
        regs[i] <= valM;
      end else if (weE && (dstE == 4'(i))) begin
        regs[i] <= valE;
      end
    end
  end

  // Read ports: storage lookup, then E bypass, then M bypass so M has highest priority.
  // Invalid ids match no entry and no enable, so they fall through as zero.
  always_comb begin
    valA = '0;
    valB = '0;
    for (int i = 0; i < NREG; i++) begin
      if (srcA == 4'(i)) valA = regs[i];
      if (srcB == 4'(i)) valB = regs[i];
    end
    if (weE && (srcA == dstE)) valA = valE;
    if (weE && (srcB == dstE)) valB = valE;
    if (weM && (srcA == dstM)) valA = valM;
    if (weM && (srcB == dstM)) valB = valM;
  end

endmodule

// File: tb/tb_y86_regfile_wb.sv
// Bench for y86_regfile_wb: a default-parameter instance checked against a
// behavioural model through expected-value queues, plus a small instance
// (NREG=8, DATA_W=32, CNT_W=4) for invalid-id and counter-wrap cases.
module tb_y86_regfile_wb;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // default instance
  logic        r0 = 1'b1, v0 = 1'b0;
  logic [3:0]  st0 = 4'd1, de0 = 4'hF, dm0 = 4'hF, sa0 = 4'h0, sb0 = 4'h0;
  logic [63:0] ve0 = 64'h0, vm0 = 64'h0, oA0, oB0;
  logic        h0;
  logic [3:0]  hc0;
  logic [31:0] ret0;

  // small instance
  logic        r1 = 1'b1, v1 = 1'b0;
  logic [3:0]  st1 = 4'd1, de1 = 4'hF, dm1 = 4'hF, sa1 = 4'h0, sb1 = 4'h0;
  logic [31:0] ve1 = 32'h0, vm1 = 32'h0, oA1, oB1;
  logic        h1;
  logic [3:0]  hc1;
  logic [3:0]  ret1;

  y86_regfile_wb dut0 (
    .clk(clk), .reset(r0), .wb_valid(v0), .wb_stat(st0),
    .dstE(de0), .valE(ve0), .dstM(dm0), .valM(vm0),
    .srcA(sa0), .srcB(sb0), .valA(oA0), .valB(oB0),
    .halted(h0), .halt_code(hc0), .retired(ret0)
  );

  y86_regfile_wb #(.DATA_W(32), .NREG(8), .CNT_W(4)) dut1 (
    .clk(clk), .reset(r1), .wb_valid(v1), .wb_stat(st1),
    .dstE(de1), .valE(ve1), .dstM(dm1), .valM(vm1),
    .srcA(sa1), .srcB(sb1), .valA(oA1), .valB(oB1),
    .halted(h1), .halt_code(hc1), .retired(ret1)
  );

  typedef struct { logic [63:0] a; logic [63:0] b; } comb_exp_t;
  typedef struct { logic h; logic [3:0] c; logic [31:0] r; } stat_exp_t;
  comb_exp_t cq[$];
  stat_exp_t sq[$];
  comb_exp_t ce;
  stat_exp_t se;

  // reference model of the default instance
  logic [63:0] m_reg [15];
  logic        m_halted = 1'b0;
  logic [3:0]  m_code = 4'd0;
  logic [31:0] m_ret = 32'd0;

  function automatic logic m_valid(input logic [3:0] id);
    return id < 4'd15;
  endfunction

  function automatic logic m_commit();
    return v0 && (st0 == 4'd1) && !m_halted && !r0;
  endfunction

  function automatic logic [63:0] m_read(input logic [3:0] id);
    if (!m_valid(id)) return 64'h0;
    if (m_commit() && m_valid(dm0) && id == dm0) return vm0;
    if (m_commit() && m_valid(de0) && id == de0) return ve0;
    return m_reg[id];
  endfunction

  task automatic drive0(input logic rst, input logic vld, input logic [3:0] stat,
                        input logic [3:0] dE, input logic [63:0] vE,
                        input logic [3:0] dM, input logic [63:0] vM,
                        input logic [3:0] sA, input logic [3:0] sB);
    comb_exp_t e;
    @(negedge clk);
    r0 = rst; v0 = vld; st0 = stat; de0 = dE; ve0 = vE; dm0 = dM; vm0 = vM;
    sa0 = sA; sb0 = sB;
    e.a = m_read(sA);
    e.b = m_read(sB);
    cq.push_back(e);
  endtask

  task automatic tick0();
    stat_exp_t e;
    if (r0) begin
      for (int i = 0; i < 15; i++) m_reg[i] = 64'h0;
      m_halted = 1'b0; m_code = 4'd0; m_ret = 32'd0;
    end else if (m_commit()) begin
      if (m_valid(de0)) m_reg[de0] = ve0;
      if (m_valid(dm0)) m_reg[dm0] = vm0;
      m_ret = m_ret + 32'd1;
    end else if (v0 && st0 != 4'd1 && !m_halted) begin
      m_halted = 1'b1; m_code = st0;
    end
    e.h = m_halted; e.c = m_code; e.r = m_ret;
    @(posedge clk);
    #1;
    sq.push_back(e);
  endtask

  task automatic drive1(input logic rst, input logic vld, input logic [3:0] stat,
                        input logic [3:0] dE, input logic [31:0] vE,
                        input logic [3:0] dM, input logic [31:0] vM,
                        input logic [3:0] sA, input logic [3:0] sB);
    @(negedge clk);
    r1 = rst; v1 = vld; st1 = stat; de1 = dE; ve1 = vE; dm1 = dM; vm1 = vM;
    sa1 = sA; sb1 = sB;
  endtask

  task automatic test_reset();
    drive0(1'b1, 1'b0, 4'd1, 4'hF, 64'h0, 4'hF, 64'h0, 4'h0, 4'hF);
    void'(cq.pop_front());
    tick0();
    se = sq.pop_front();
    checks++;
    if (h0 !== 1'b0 || hc0 !== 4'd0 || ret0 !== 32'd0 || {h0, hc0, ret0} !== {se.h, se.c, se.r}) begin
      errors++;
      $display("FAIL reset_status: got h=%b code=%0d ret=%0d expected 0/0/0", h0, hc0, ret0);
    end
    for (int i = 0; i < 15; i++) begin
      drive0(1'b0, 1'b0, 4'd1, 4'hF, 64'h0, 4'hF, 64'h0, 4'(i), 4'hF);
      #1;
      ce = cq.pop_front();
      checks++;
      if (oA0 !== ce.a || oB0 !== ce.b || oA0 !== 64'h0) begin
        errors++;
        $display("FAIL reset_read r%0d: got A=%h B=%h expected 0/0", i, oA0, oB0);
      end
    end
    drive1(1'b1, 1'b0, 4'd1, 4'hF, 32'h0, 4'hF, 32'h0, 4'h0, 4'hF);
    @(posedge clk); #1;
    checks++;
    if (h1 !== 1'b0 || ret1 !== 4'd0) begin
      errors++;
      $display("FAIL reset_status_small: got h=%b ret=%0d expected 0/0", h1, ret1);
    end
    for (int i = 0; i < 8; i++) begin
      drive1(1'b0, 1'b0, 4'd1, 4'hF, 32'h0, 4'hF, 32'h0, 4'(i), 4'(i));
      #1;
      checks++;
      if (oA1 !== 32'h0 || oB1 !== 32'h0) begin
        errors++;
        $display("FAIL reset_read_small r%0d: got A=%h B=%h expected 0/0", i, oA1, oB1);
      end
    end
  endtask

  task automatic test_write_bypass();
    drive0(1'b0, 1'b1, 4'd1, 4'd3, 64'h1234, 4'hF, 64'h0, 4'd3, 4'hF);
    #1;
    ce = cq.pop_front();
    checks++;
    if (oA0 !== 64'h1234 || oA0 !== ce.a || oB0 !== ce.b) begin
      errors++;
      $display("FAIL bypass_e: got A=%h B=%h expected %h/%h", oA0, oB0, ce.a, ce.b);
    end
    tick0();
    se = sq.pop_front();
    checks++;
    if (ret0 !== 32'd1 || {h0, hc0, ret0} !== {se.h, se.c, se.r}) begin
      errors++;
      $display("FAIL write_retired: got ret=%0d expected %0d", ret0, se.r);
    end
    drive0(1'b0, 1'b0, 4'd1, 4'hF, 64'h0, 4'hF, 64'h0, 4'd3, 4'd3);
    #1;
    ce = cq.pop_front();
    checks++;
    if (oA0 !== 64'h1234 || oB0 !== 64'h1234 || oA0 !== ce.a) begin
      errors++;
      $display("FAIL write_stored: got A=%h B=%h expected 1234", oA0, oB0);
    end
  endtask

  task automatic test_collision();
    drive0(1'b0, 1'b1, 4'd1, 4'd4, 64'hAA, 4'd4, 64'hBB, 4'd0, 4'd4);
    #1;
    ce = cq.pop_front();
    checks++;
    if (oB0 !== 64'hBB || oB0 !== ce.b || oA0 !== ce.a) begin
      errors++;
      $display("FAIL collision_bypass: got A=%h B=%h expected %h/%h", oA0, oB0, ce.a, ce.b);
    end
    tick0();
    se = sq.pop_front();
    checks++;
    if (ret0 !== 32'd2 || ret0 !== se.r) begin
      errors++;
      $display("FAIL collision_retired: got %0d expected 2", ret0);
    end
    drive0(1'b0, 1'b0, 4'd1, 4'hF, 64'h0, 4'hF, 64'h0, 4'd4, 4'd4);
    #1;
    ce = cq.pop_front();
    checks++;
    if (oA0 !== 64'hBB || oB0 !== 64'hBB || oA0 !== ce.a) begin
      errors++;
      $display("FAIL collision_stored: got A=%h B=%h expected bb", oA0, oB0);
    end
  endtask

  task automatic test_halt();
    drive0(1'b1, 1'b0, 4'd1, 4'hF, 64'h0, 4'hF, 64'h0, 4'h0, 4'h0);
    void'(cq.pop_front());
    tick0();
    void'(sq.pop_front());
    for (int k = 0; k < 5; k++) begin
      drive0(1'b0, 1'b1, 4'd1, 4'(k), 64'(100 + k), 4'hF, 64'h0, 4'(k), 4'hF);
      #1;
      ce = cq.pop_front();
      checks++;
      if (oA0 !== ce.a || oB0 !== ce.b) begin
        errors++;
        $display("FAIL halt_prefill r%0d: got A=%h expected %h", k, oA0, ce.a);
      end
      tick0();
      void'(sq.pop_front());
    end
    drive0(1'b0, 1'b1, 4'd3, 4'd2, 64'h77, 4'hF, 64'h0, 4'd2, 4'd4);
    #1;
    ce = cq.pop_front();
    checks++;
    if (oA0 !== 64'd102 || oA0 !== ce.a || oB0 !== ce.b) begin
      errors++;
      $display("FAIL halt_fault_nobypass: got A=%h B=%h expected %h/%h", oA0, oB0, ce.a, ce.b);
    end
    tick0();
    se = sq.pop_front();
    checks++;
    if (h0 !== 1'b1 || hc0 !== 4'd3 || ret0 !== 32'd5 || {h0, hc0, ret0} !== {se.h, se.c, se.r}) begin
      errors++;
      $display("FAIL halt_status: got h=%b code=%0d ret=%0d expected 1/3/5", h0, hc0, ret0);
    end
    drive0(1'b0, 1'b1, 4'd1, 4'd2, 64'h99, 4'd4, 64'h88, 4'd2, 4'd4);
    #1;
    ce = cq.pop_front();
    checks++;
    if (oA0 !== 64'd102 || oB0 !== 64'd104 || oA0 !== ce.a || oB0 !== ce.b) begin
      errors++;
      $display("FAIL halted_nobypass: got A=%h B=%h expected 66/68", oA0, oB0);
    end
    tick0();
    se = sq.pop_front();
    checks++;
    if (h0 !== 1'b1 || hc0 !== 4'd3 || ret0 !== 32'd5 || ret0 !== se.r) begin
      errors++;
      $display("FAIL halted_frozen: got h=%b code=%0d ret=%0d expected 1/3/5", h0, hc0, ret0);
    end
    drive0(1'b0, 1'b0, 4'd1, 4'hF, 64'h0, 4'hF, 64'h0, 4'd2, 4'd4);
    #1;
    ce = cq.pop_front();
    checks++;
    if (oA0 !== 64'd102 || oB0 !== 64'd104 || oA0 !== ce.a) begin
      errors++;
      $display("FAIL halted_regs_kept: got A=%h B=%h expected 66/68", oA0, oB0);
    end
    drive0(1'b1, 1'b1, 4'd1, 4'd2, 64'h55, 4'hF, 64'h0, 4'd2, 4'hF);
    #1;
    ce = cq.pop_front();
    checks++;
    if (oA0 !== ce.a) begin
      errors++;
      $display("FAIL halt_reset_read: got A=%h expected %h", oA0, ce.a);
    end
    tick0();
    se = sq.pop_front();
    checks++;
    if (h0 !== 1'b0 || hc0 !== 4'd0 || ret0 !== 32'd0 || {h0, hc0, ret0} !== {se.h, se.c, se.r}) begin
      errors++;
      $display("FAIL halt_reset_status: got h=%b code=%0d ret=%0d expected 0/0/0", h0, hc0, ret0);
    end
    drive0(1'b0, 1'b0, 4'd1, 4'hF, 64'h0, 4'hF, 64'h0, 4'd2, 4'd4);
    #1;
    ce = cq.pop_front();
    checks++;
    if (oA0 !== 64'h0 || oB0 !== 64'h0 || oA0 !== ce.a) begin
      errors++;
      $display("FAIL halt_reset_cleared: got A=%h B=%h expected 0/0", oA0, oB0);
    end
  endtask

  task automatic test_random();
    logic       rst, vld;
    logic [3:0] stat;
    for (int n = 0; n < 400; n++) begin
      rst  = ($urandom_range(0, 39) == 0);
      vld  = ($urandom_range(0, 3) != 0);
      stat = ($urandom_range(0, 11) == 0) ? 4'($urandom_range(0, 15)) : 4'd1;
      drive0(rst, vld, stat, 4'($urandom_range(0, 15)), {$urandom(), $urandom()},
             4'($urandom_range(0, 15)), {$urandom(), $urandom()},
             4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
      #1;
      ce = cq.pop_front();
      checks++;
      if (oA0 !== ce.a || oB0 !== ce.b) begin
        errors++;
        $display("FAIL random_read #%0d: got A=%h B=%h expected %h/%h", n, oA0, oB0, ce.a, ce.b);
      end
      tick0();
      se = sq.pop_front();
      checks++;
      if ({h0, hc0, ret0} !== {se.h, se.c, se.r}) begin
        errors++;
        $display("FAIL random_status #%0d: got h=%b code=%0d ret=%0d expected %b/%0d/%0d",
                 n, h0, hc0, ret0, se.h, se.c, se.r);
      end
    end
  endtask

  task automatic test_invalid_ids();
    drive1(1'b1, 1'b0, 4'd1, 4'hF, 32'h0, 4'hF, 32'h0, 4'h0, 4'h0);
    drive1(1'b0, 1'b1, 4'd1, 4'd2, 32'hC, 4'hF, 32'h0, 4'd2, 4'hF);
    #1;
    checks++;
    if (oA1 !== 32'hC) begin
      errors++;
      $display("FAIL small_bypass: got A=%h expected c", oA1);
    end
    drive1(1'b0, 1'b1, 4'd1, 4'd9, 32'h5, 4'd12, 32'h6, 4'd9, 4'd12);
    #1;
    checks++;
    if (oA1 !== 32'h0 || oB1 !== 32'h0) begin
      errors++;
      $display("FAIL invalid_id_bypass: got A=%h B=%h expected 0/0", oA1, oB1);
    end
    @(posedge clk); #1;
    checks++;
    if (ret1 !== 4'd2 || h1 !== 1'b0) begin
      errors++;
      $display("FAIL invalid_id_retired: got ret=%0d h=%b expected 2/0", ret1, h1);
    end
    for (int i = 0; i < 8; i++) begin
      drive1(1'b0, 1'b0, 4'd1, 4'hF, 32'h0, 4'hF, 32'h0, 4'(i), 4'(i));
      #1;
      checks++;
      if (oA1 !== ((i == 2) ? 32'hC : 32'h0) || oB1 !== oA1) begin
        errors++;
        $display("FAIL invalid_id_regs r%0d: got A=%h B=%h", i, oA1, oB1);
      end
    end
    drive1(1'b0, 1'b0, 4'd1, 4'hF, 32'h0, 4'hF, 32'h0, 4'd9, 4'hF);
    #1;
    checks++;
    if (oA1 !== 32'h0 || oB1 !== 32'h0) begin
      errors++;
      $display("FAIL invalid_id_read: got A=%h B=%h expected 0/0", oA1, oB1);
    end
  endtask

  task automatic test_wrap();
    drive1(1'b1, 1'b0, 4'd1, 4'hF, 32'h0, 4'hF, 32'h0, 4'h0, 4'h0);
    @(posedge clk); #1;
    for (int k = 0; k < 17; k++) begin
      drive1(1'b0, 1'b1, 4'd1, (k == 0) ? 4'd1 : 4'hF, 32'h11, 4'hF, 32'h0, 4'hF, 4'hF);
      @(posedge clk); #1;
      checks++;
      if (ret1 !== 4'(k + 1)) begin
        errors++;
        $display("FAIL wrap_count #%0d: got %0d expected %0d", k, ret1, 4'(k + 1));
      end
    end
    drive1(1'b1, 1'b1, 4'd1, 4'd1, 32'hAB, 4'hF, 32'h0, 4'd1, 4'hF);
    #1;
    checks++;
    if (oA1 !== 32'h11) begin
      errors++;
      $display("FAIL reset_no_bypass: got A=%h expected 11", oA1);
    end
    @(posedge clk); #1;
    checks++;
    if (ret1 !== 4'd0) begin
      errors++;
      $display("FAIL reset_commit_count: got %0d expected 0", ret1);
    end
    drive1(1'b0, 1'b0, 4'd1, 4'hF, 32'h0, 4'hF, 32'h0, 4'd1, 4'hF);
    #1;
    checks++;
    if (oA1 !== 32'h0) begin
      errors++;
      $display("FAIL reset_commit_write: got A=%h expected 0", oA1);
    end
  endtask

  initial begin
    test_reset();
    test_write_bypass();
    test_collision();
    test_halt();
    test_random();
    test_invalid_ids();
    test_wrap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
